// File: rtl/mirfak_id_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mirfak_id_stage
// Brief    : RV32I decode with EX/MEM/WB operand forwarding, load-use stall
//            detection, decode exceptions and the registered ID/EX stage.
// Revision : 1.0
// ============================================================================
module mirfak_id_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_pc4_i,
    input  logic [31:0] id_instruction_i,
    input  logic        id_if_exception_i,
    input  logic [3:0]  id_if_xcause_i,
    input  logic        id_bubble_i,
    output logic [4:0]  rf_rs1_addr_o,
    output logic [4:0]  rf_rs2_addr_o,
    input  logic [31:0] rf_rs1_data_i,
    input  logic [31:0] rf_rs2_data_i,
    input  logic [4:0]  ex_fwd_rd_i,
    input  logic [4:0]  mem_fwd_rd_i,
    input  logic [4:0]  wb_fwd_rd_i,
    input  logic        ex_fwd_we_i,
    input  logic        mem_fwd_we_i,
    input  logic        wb_fwd_we_i,
    input  logic        ex_fwd_load_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic [31:0] mem_fwd_data_i,
    input  logic [31:0] wb_fwd_data_i,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_pc4_o,
    output logic [31:0] ex_operand_a_o,
    output logic [31:0] ex_operand_b_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_we_o,
    output logic [3:0]  ex_alu_op_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_is_load_o,
    output logic        ex_is_store_o,
    output logic        ex_is_branch_o,
    output logic        ex_is_jal_o,
    output logic        ex_is_jalr_o,
    output logic        ex_is_csr_o,
    output logic        ex_is_xret_o,
    output logic        ex_exception_o,
    output logic [3:0]  ex_xcause_o,
    output logic        ex_bubble_o,
    input  logic        idex_enable_i,
    input  logic        idex_clear_i,
    output logic        id_stall_o
);

    localparam logic [6:0] C_OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] C_OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] C_OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] C_OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] C_OPC_STORE    = 7'b0100011;
    localparam logic [6:0] C_OPC_OP       = 7'b0110011;
    localparam logic [6:0] C_OPC_LUI      = 7'b0110111;
    localparam logic [6:0] C_OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] C_OPC_JALR     = 7'b1100111;
    localparam logic [6:0] C_OPC_JAL      = 7'b1101111;
    localparam logic [6:0] C_OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] C_INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] C_INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] C_INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] C_INSTR_MRET   = 32'h3020_0073;

    localparam logic [3:0] C_ALU_ADD   = 4'd0;
    localparam logic [3:0] C_ALU_SUB   = 4'd1;
    localparam logic [3:0] C_ALU_SLL   = 4'd2;
    localparam logic [3:0] C_ALU_SLT   = 4'd3;
    localparam logic [3:0] C_ALU_SLTU  = 4'd4;
    localparam logic [3:0] C_ALU_XOR   = 4'd5;
    localparam logic [3:0] C_ALU_SRL   = 4'd6;
    localparam logic [3:0] C_ALU_SRA   = 4'd7;
    localparam logic [3:0] C_ALU_OR    = 4'd8;
    localparam logic [3:0] C_ALU_AND   = 4'd9;
    localparam logic [3:0] C_ALU_PASSB = 4'd10;

    localparam logic [3:0] C_CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] C_CAUSE_BREAK   = 4'd3;
    localparam logic [3:0] C_CAUSE_ECALL   = 4'd11;

    // Raw instruction fields drive legality and the regfile address ports.
    logic [6:0]  w_raw_opcode;
    logic [2:0]  w_raw_funct3;
    logic [6:0]  w_raw_funct7;
    assign w_raw_opcode  = id_instruction_i[6:0];
    assign w_raw_funct3  = id_instruction_i[14:12];
    assign w_raw_funct7  = id_instruction_i[31:25];
    assign rf_rs1_addr_o = id_instruction_i[19:15];
    assign rf_rs2_addr_o = id_instruction_i[24:20];

    // FENCE has no architectural effect here, so the datapath sees a NOP.
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    assign w_instr  = (w_raw_opcode == C_OPC_MISC_MEM) ? C_INSTR_NOP : id_instruction_i;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];

    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    assign w_fwd_rs1 = (w_rs1 == 5'd0)                            ? 32'd0          :
                       (ex_fwd_we_i  && (ex_fwd_rd_i  == w_rs1))  ? ex_fwd_data_i  :
                       (mem_fwd_we_i && (mem_fwd_rd_i == w_rs1))  ? mem_fwd_data_i :
                       (wb_fwd_we_i  && (wb_fwd_rd_i  == w_rs1))  ? wb_fwd_data_i  :
                                                                    rf_rs1_data_i;
    assign w_fwd_rs2 = (w_rs2 == 5'd0)                            ? 32'd0          :
                       (ex_fwd_we_i  && (ex_fwd_rd_i  == w_rs2))  ? ex_fwd_data_i  :
                       (mem_fwd_we_i && (mem_fwd_rd_i == w_rs2))  ? mem_fwd_data_i :
                       (wb_fwd_we_i  && (wb_fwd_rd_i  == w_rs2))  ? wb_fwd_data_i  :
                                                                    rf_rs2_data_i;

    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'd0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? C_ALU_SUB : C_ALU_ADD;
            3'd1:    op = C_ALU_SLL;
            3'd2:    op = C_ALU_SLT;
            3'd3:    op = C_ALU_SLTU;
            3'd4:    op = C_ALU_XOR;
            3'd5:    op = alt ? C_ALU_SRA : C_ALU_SRL;
            3'd6:    op = C_ALU_OR;
            default: op = C_ALU_AND;
        endcase
        return op;
    endfunction

    logic        w_illegal;
    always_comb begin
        w_illegal = 1'b0;
        if (id_instruction_i[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_raw_opcode)
                C_OPC_LOAD:     w_illegal = (w_raw_funct3 == 3'd3) || (w_raw_funct3 == 3'd6) || (w_raw_funct3 == 3'd7);
                C_OPC_STORE:    w_illegal = (w_raw_funct3 > 3'd2);
                C_OPC_BRANCH:   w_illegal = (w_raw_funct3 == 3'd2) || (w_raw_funct3 == 3'd3);
                C_OPC_JALR:     w_illegal = (w_raw_funct3 != 3'd0);
                C_OPC_JAL, C_OPC_LUI, C_OPC_AUIPC:
                                w_illegal = 1'b0;
                C_OPC_OP_IMM:   w_illegal = ((w_raw_funct3 == 3'd1) || (w_raw_funct3 == 3'd5)) &&
                                            (w_raw_funct7 != 7'h00) && (w_raw_funct7 != 7'h20);
                C_OPC_OP:       w_illegal = !((w_raw_funct7 == 7'h00) ||
                                              ((w_raw_funct7 == 7'h20) &&
                                               ((w_raw_funct3 == 3'd0) || (w_raw_funct3 == 3'd5))));
                C_OPC_MISC_MEM: w_illegal = (w_raw_funct3 != 3'd0);
                C_OPC_SYSTEM: begin
                    if (w_raw_funct3 == 3'd0)
                        w_illegal = !((id_instruction_i == C_INSTR_ECALL) ||
                                      (id_instruction_i == C_INSTR_EBREAK) ||
                                      (id_instruction_i == C_INSTR_MRET));
                    else
                        w_illegal = (w_raw_funct3 == 3'd4);
                end
                default:        w_illegal = 1'b1;
            endcase
        end
    end

    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_opb_rs2;
    logic [31:0] w_imm;
    logic [31:0] w_opa;
    logic [3:0]  w_alu;
    logic        w_we_class;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_csr;
    logic        w_is_xret;
    always_comb begin
        w_rs1_used  = 1'b0;
        w_rs2_used  = 1'b0;
        w_opb_rs2   = 1'b0;
        w_imm       = 32'd0;
        w_opa       = w_fwd_rs1;
        w_alu       = C_ALU_ADD;
        w_we_class  = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        w_is_jal    = 1'b0;
        w_is_jalr   = 1'b0;
        w_is_csr    = 1'b0;
        w_is_xret   = 1'b0;
        case (w_opcode)
            C_OPC_OP: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_opb_rs2  = 1'b1;
                w_alu      = alu_from_funct3(w_funct3, w_instr[30]);
                w_we_class = 1'b1;
            end
            C_OPC_OP_IMM: begin
                w_rs1_used = 1'b1;
                w_imm      = w_imm_i;
                // Only SRAI borrows funct7[5]; ADDI with a negative immediate must stay ADD.
                w_alu      = alu_from_funct3(w_funct3, (w_funct3 == 3'd5) && w_instr[30]);
                w_we_class = 1'b1;
            end
            C_OPC_LOAD: begin
                w_rs1_used = 1'b1;
                w_imm      = w_imm_i;
                w_we_class = 1'b1;
                w_is_load  = 1'b1;
            end
            C_OPC_STORE: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm      = w_imm_s;
                w_is_store = 1'b1;
            end
            C_OPC_BRANCH: begin
                w_rs1_used  = 1'b1;
                w_rs2_used  = 1'b1;
                w_opb_rs2   = 1'b1;
                w_imm       = w_imm_b;
                w_is_branch = 1'b1;
            end
            C_OPC_JALR: begin
                w_rs1_used = 1'b1;
                w_imm      = w_imm_i;
                w_we_class = 1'b1;
                w_is_jalr  = 1'b1;
            end
            C_OPC_JAL: begin
                w_imm      = w_imm_j;
                w_we_class = 1'b1;
                w_is_jal   = 1'b1;
            end
            C_OPC_LUI: begin
                w_imm      = w_imm_u;
                w_opa      = 32'd0;
                w_alu      = C_ALU_PASSB;
                w_we_class = 1'b1;
            end
            C_OPC_AUIPC: begin
                w_imm      = w_imm_u;
                w_opa      = id_pc_i;
                w_we_class = 1'b1;
            end
            C_OPC_SYSTEM: begin
                w_imm = w_imm_i;
                if (w_funct3 != 3'd0) begin
                    w_is_csr   = 1'b1;
                    w_we_class = 1'b1;
                    w_rs1_used = !w_funct3[2];
                end else begin
                    w_is_xret  = (w_instr == C_INSTR_MRET);
                end
            end
            default: begin
                w_imm = 32'd0;
            end
        endcase
    end

    logic        w_exception;
    logic [3:0]  w_xcause;
    always_comb begin
        w_exception = 1'b1;
        w_xcause    = 4'd0;
        if (id_if_exception_i)
            w_xcause = id_if_xcause_i;
        else if (w_illegal)
            w_xcause = C_CAUSE_ILLEGAL;
        else if (id_instruction_i == C_INSTR_EBREAK)
            w_xcause = C_CAUSE_BREAK;
        else if (id_instruction_i == C_INSTR_ECALL)
            w_xcause = C_CAUSE_ECALL;
        else
            w_exception = 1'b0;
    end

    assign id_stall_o = !id_bubble_i && ex_fwd_load_i && ex_fwd_we_i && (ex_fwd_rd_i != 5'd0) &&
                        ((w_rs1_used && (ex_fwd_rd_i == w_rs1)) ||
                         (w_rs2_used && (ex_fwd_rd_i == w_rs2)));

    logic w_load_bubble;
    logic w_keep;
    assign w_load_bubble = rst_i || idex_clear_i || (idex_enable_i && (id_bubble_i || id_stall_o));
    assign w_keep        = !w_exception;

    always_ff @(posedge clk_i) begin
        if (w_load_bubble) begin
            ex_pc_o        <= 32'd0;
            ex_pc4_o       <= 32'd0;
            ex_operand_a_o <= 32'd0;
            ex_operand_b_o <= 32'd0;
            ex_rs2_data_o  <= 32'd0;
            ex_rs1_data_o  <= 32'd0;
            ex_imm_o       <= 32'd0;
            ex_rd_o        <= 5'd0;
            ex_we_o        <= 1'b0;
            ex_alu_op_o    <= 4'd0;
            ex_funct3_o    <= 3'd0;
            ex_is_load_o   <= 1'b0;
            ex_is_store_o  <= 1'b0;
            ex_is_branch_o <= 1'b0;
            ex_is_jal_o    <= 1'b0;
            ex_is_jalr_o   <= 1'b0;
            ex_is_csr_o    <= 1'b0;
            ex_is_xret_o   <= 1'b0;
            ex_exception_o <= 1'b0;
            ex_xcause_o    <= 4'd0;
            ex_bubble_o    <= 1'b1;
        end else if (idex_enable_i) begin
            ex_pc_o        <= id_pc_i;
            ex_pc4_o       <= id_pc4_i;
            ex_operand_a_o <= w_opa;
            ex_operand_b_o <= w_opb_rs2 ? w_fwd_rs2 : w_imm;
            ex_rs2_data_o  <= w_fwd_rs2;
            ex_rs1_data_o  <= w_fwd_rs1;
            ex_imm_o       <= w_imm;
            ex_rd_o        <= w_rd;
            ex_we_o        <= w_keep && w_we_class && (w_rd != 5'd0);
            ex_alu_op_o    <= w_alu;
            ex_funct3_o    <= w_raw_funct3;
            ex_is_load_o   <= w_keep && w_is_load;
            ex_is_store_o  <= w_keep && w_is_store;
            ex_is_branch_o <= w_keep && w_is_branch;
            ex_is_jal_o    <= w_keep && w_is_jal;
            ex_is_jalr_o   <= w_keep && w_is_jalr;
            ex_is_csr_o    <= w_keep && w_is_csr;
            ex_is_xret_o   <= w_keep && w_is_xret;
            ex_exception_o <= w_exception;
            ex_xcause_o    <= w_xcause;
            ex_bubble_o    <= 1'b0;
        end
    end

endmodule
`default_nettype wire
